pcileech_eth_tx_arb: RTL and testbench

//  Round-robin, frame-locked arbiter that shares the single 256-bit ETH transmit path (eth_din/din_wr_en/din_ready)

---
 rtl/pcileech_eth_tx_arb_if.sv | 32 +++
 rtl/pcileech_eth_tx_arb.sv | 99 +++++++++
 tb/tb_pcileech_eth_tx_arb.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_eth_tx_arb_if.sv
// Bundle for the two producer streams, the shared ETH transmit beat path and the arbiter status outputs.
interface pcileech_eth_tx_arb_if #(
    parameter int unsigned CNT_W = 16
);
    logic [255:0]     s0_data;
    logic             s0_valid;
    logic             s0_last;
    logic             s0_rd_en;
    logic [255:0]     s1_data;
    logic             s1_valid;
    logic             s1_last;
    logic             s1_rd_en;
    logic [255:0]     dout;
    logic             dout_wr_en;
    logic             dout_last;
    logic             dout_ready;
    logic             err_timeout;
    logic [CNT_W-1:0] cnt_frm0;
    logic [CNT_W-1:0] cnt_frm1;

    // Arbiter side
    modport master (
        input  s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last, dout_ready,
        output s0_rd_en, s1_rd_en, dout, dout_wr_en, dout_last, err_timeout, cnt_frm0, cnt_frm1
    );

    // Producers and ETH buffer side
    modport slave (
        output s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last, dout_ready,
        input  s0_rd_en, s1_rd_en, dout, dout_wr_en, dout_last, err_timeout, cnt_frm0, cnt_frm1
    );
endinterface

// File: rtl/pcileech_eth_tx_arb.sv
// Round-robin, frame-locked arbiter sharing the 256-bit ETH transmit path between the TLP (src0)
// and CFG/status (src1) streams, with per-source frame counters and a mid-frame stall watchdog.
module pcileech_eth_tx_arb #(
    parameter int unsigned PARAM_TIMEOUT = 1024,
    parameter int unsigned PARAM_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pcileech_eth_tx_arb_if.master bus
);
    localparam int unsigned WD_W = $clog2(PARAM_TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(PARAM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                 state;
    logic                   rr_last;
    logic [WD_W-1:0]        wdog;
    logic [PARAM_CNT_W-1:0] cnt0_q;
    logic [PARAM_CNT_W-1:0] cnt1_q;

    logic out_free_c;
    logic rd0_c;
    logic rd1_c;
    logic acc_c;
    logic acc_last_c;
    logic wd_expire_c;

    // Output register may take a new beat when empty or draining this cycle
    assign out_free_c  = ~bus.dout_wr_en | bus.dout_ready;
    assign rd0_c       = (state == GRANT0) & bus.s0_valid & out_free_c;
    assign rd1_c       = (state == GRANT1) & bus.s1_valid & out_free_c;
    assign acc_c       = rd0_c | rd1_c;
    assign acc_last_c  = (rd0_c & bus.s0_last) | (rd1_c & bus.s1_last);
    // Accept always beats expiry, so a last beat on the final watchdog cycle completes normally
    assign wd_expire_c = (state != IDLE) & ~acc_c & out_free_c & (wdog == WD_MAX);

    assign bus.s0_rd_en = rd0_c;
    assign bus.s1_rd_en = rd1_c;
    assign bus.cnt_frm0 = cnt0_q;
    assign bus.cnt_frm1 = cnt1_q;

    // Grant FSM, watchdog, counters and output beat register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_last         <= 1'b1;
            wdog            <= '0;
            cnt0_q          <= '0;
            cnt1_q          <= '0;
            bus.dout        <= '0;
            bus.dout_wr_en  <= 1'b0;
            bus.dout_last   <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.err_timeout <= 1'b0;

            if (out_free_c) begin
                bus.dout_wr_en <= acc_c;
                if (acc_c) begin
                    bus.dout      <= rd1_c ? bus.s1_data : bus.s0_data;
                    bus.dout_last <= rd1_c ? bus.s1_last : bus.s0_last;
                end
            end

            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (bus.s0_valid && (!bus.s1_valid || rr_last)) begin
                        state <= GRANT0;
                    end else if (bus.s1_valid) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (acc_c) begin
                        wdog <= '0;
                        if (acc_last_c) begin
                            state   <= IDLE;
                            rr_last <= (state == GRANT1);
                            if (state == GRANT0) begin
                                cnt0_q <= cnt0_q + PARAM_CNT_W'(1);
                            end else begin
                                cnt1_q <= cnt1_q + PARAM_CNT_W'(1);
                            end
                        end
                    end else if (wd_expire_c) begin
                        state           <= IDLE;
                        rr_last         <= (state == GRANT1);
                        bus.err_timeout <= 1'b1;
                    end else if (out_free_c) begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcileech_eth_tx_arb.sv
// Directed bench for pcileech_eth_tx_arb: queue-fed source drivers, output beat recorder, per-scenario tasks.
module tb_pcileech_eth_tx_arb;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic         last;
        logic [255:0] data;
    } beat_t;

    typedef struct packed {
        logic         last;
        logic [255:0] data;
        logic [31:0]  cyc;
    } obeat_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pcileech_eth_tx_arb_if #(.CNT_W(CW)) bus ();

    pcileech_eth_tx_arb #(
        .PARAM_TIMEOUT(TO),
        .PARAM_CNT_W  (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    beat_t  q0[$];
    beat_t  q1[$];
    obeat_t oq[$];
    int     cyc     = 0;
    int     errs    = 0;
    int     err_cyc = 0;
    int     checks  = 0;
    int     passes  = 0;
    int     e0      = 0;
    int     e1      = 0;
    bit     a0      = 1'b0;
    bit     a1      = 1'b0;

    // Sources present queue heads after each edge; the recorder samples mid-cycle
    initial begin
        beat_t h;
        bus.s0_valid   = 1'b0;
        bus.s0_data    = '0;
        bus.s0_last    = 1'b0;
        bus.s1_valid   = 1'b0;
        bus.s1_data    = '0;
        bus.s1_last    = 1'b0;
        bus.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (a0 && q0.size() != 0) q0.delete(0);
            if (a1 && q1.size() != 0) q1.delete(0);
            h = (q0.size() != 0) ? q0[0] : '0;
            bus.s0_valid = (q0.size() != 0);
            bus.s0_data  = h.data;
            bus.s0_last  = h.last;
            h = (q1.size() != 0) ? q1[0] : '0;
            bus.s1_valid = (q1.size() != 0);
            bus.s1_data  = h.data;
            bus.s1_last  = h.last;
            @(negedge clk);
            a0 = bus.s0_rd_en;
            a1 = bus.s1_rd_en;
            if (bus.dout_wr_en && bus.dout_ready) oq.push_back({bus.dout_last, bus.dout, 32'(cyc)});
            if (bus.err_timeout) begin
                errs++;
                err_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input int max, output bit ok);
        int n;
        n = 0;
        tick(1);
        while ((q0.size() != 0 || q1.size() != 0 || bus.dout_wr_en) && n < max) begin
            tick(1);
            n++;
        end
        ok = (n < max);
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        q0.push_back({1'b1, 256'h01});
        q1.push_back({1'b1, 256'h11});
        tick(3);
        checks++; if (bus.dout_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b expected 0", bus.dout_wr_en); else passes++;
        checks++; if (bus.dout !== 256'h0) $display("FAIL rst_dout: got %0h expected 0", bus.dout); else passes++;
        checks++; if (bus.dout_last !== 1'b0) $display("FAIL rst_last: got %b expected 0", bus.dout_last); else passes++;
        checks++; if (bus.err_timeout !== 1'b0) $display("FAIL rst_err: got %b expected 0", bus.err_timeout); else passes++;
        checks++; if (bus.cnt_frm0 !== CW'(0)) $display("FAIL rst_cnt0: got %0d expected 0", bus.cnt_frm0); else passes++;
        checks++; if (bus.cnt_frm1 !== CW'(0)) $display("FAIL rst_cnt1: got %0d expected 0", bus.cnt_frm1); else passes++;
        checks++; if ((bus.s0_rd_en | bus.s1_rd_en) !== 1'b0) $display("FAIL rst_rd_en: got %b%b expected 00", bus.s0_rd_en, bus.s1_rd_en); else passes++;
        oq.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_drain(50, ok);
        checks++; if (!ok) $display("FAIL rst_drain: got timeout expected drain"); else passes++;
        checks++; if (oq.size() != 2) $display("FAIL rst_nbeats: got %0d expected 2", oq.size()); else passes++;
        if (oq.size() == 2) begin
            checks++; if (oq[0].data !== 256'h01) $display("FAIL rst_first_src: got %0h expected 1", oq[0].data); else passes++;
            checks++; if (oq[1].data !== 256'h11) $display("FAIL rst_second_src: got %0h expected 11", oq[1].data); else passes++;
        end
        e0 = 1;
        e1 = 1;
        checks++; if (bus.cnt_frm0 !== CW'(e0)) $display("FAIL rst_cnt0_after: got %0d expected %0d", bus.cnt_frm0, e0); else passes++;
        checks++; if (bus.cnt_frm1 !== CW'(e1)) $display("FAIL rst_cnt1_after: got %0d expected %0d", bus.cnt_frm1, e1); else passes++;
    endtask

    task automatic test_contention();
        bit           ok;
        logic [255:0] exp_d;
        oq.delete();
        for (int i = 0; i < 5; i++) begin
            q0.push_back({1'b0, 256'(32'h100 + 32'(2 * i))});
            q0.push_back({1'b1, 256'(32'h101 + 32'(2 * i))});
            q1.push_back({1'b0, 256'(32'h200 + 32'(2 * i))});
            q1.push_back({1'b1, 256'(32'h201 + 32'(2 * i))});
        end
        wait_drain(400, ok);
        checks++; if (!ok) $display("FAIL cont_drain: got timeout expected drain"); else passes++;
        checks++; if (oq.size() != 20) $display("FAIL cont_nbeats: got %0d expected 20", oq.size()); else passes++;
        if (oq.size() == 20) begin
            for (int f = 0; f < 10; f++) begin
                for (int b = 0; b < 2; b++) begin
                    exp_d = 256'(((f % 2 == 0) ? 32'h100 : 32'h200) + 32'((f / 2) * 2 + b));
                    checks++;
                    if (oq[2 * f + b].data !== exp_d || oq[2 * f + b].last !== (b == 1))
                        $display("FAIL cont_beat%0d: got %0h/%b expected %0h/%b", 2 * f + b,
                                 oq[2 * f + b].data, oq[2 * f + b].last, exp_d, (b == 1));
                    else passes++;
                end
            end
        end
        e0 += 5;
        e1 += 5;
        checks++; if (bus.cnt_frm0 !== CW'(e0)) $display("FAIL cont_cnt0: got %0d expected %0d", bus.cnt_frm0, e0 % 16); else passes++;
        checks++; if (bus.cnt_frm1 !== CW'(e1)) $display("FAIL cont_cnt1: got %0d expected %0d", bus.cnt_frm1, e1 % 16); else passes++;
    endtask

    task automatic test_single_frame();
        bit ok;
        int p;
        oq.delete();
        p = cyc;
        q0.push_back({1'b0, 256'hA1});
        q0.push_back({1'b0, 256'hA2});
        q0.push_back({1'b1, 256'hA3});
        wait_drain(50, ok);
        checks++; if (!ok) $display("FAIL single_drain: got timeout expected drain"); else passes++;
        checks++; if (oq.size() != 3) $display("FAIL single_nbeats: got %0d expected 3", oq.size()); else passes++;
        if (oq.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (oq[k].data !== 256'(32'hA1 + 32'(k)) || oq[k].last !== (k == 2) || oq[k].cyc !== 32'(p + 3 + k))
                    $display("FAIL single_beat%0d: got %0h/%b@%0d expected %0h/%b@%0d", k, oq[k].data, oq[k].last,
                             oq[k].cyc, 32'hA1 + k, (k == 2), p + 3 + k);
                else passes++;
            end
        end
        e0 += 1;
        checks++; if (bus.cnt_frm0 !== CW'(e0)) $display("FAIL single_cnt0: got %0d expected %0d", bus.cnt_frm0, e0 % 16); else passes++;
    endtask

    task automatic test_back_pressure();
        bit           ok;
        int           n;
        int           bad_hold;
        int           bad_rd;
        int           errs0;
        logic [255:0] held;
        oq.delete();
        errs0 = errs;
        for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 256'(32'h300 + 32'(i))});
        n = 0;
        while (oq.size() == 0 && n < 20) begin
            tick(1);
            n++;
        end
        checks++; if (n >= 20) $display("FAIL bp_start: got no beat expected beat"); else passes++;
        @(posedge clk);
        #2;
        bus.dout_ready = 1'b0;
        tick(1);
        held     = bus.dout;
        bad_hold = 0;
        bad_rd   = 0;
        repeat (50) begin
            tick(1);
            if (bus.dout !== held || bus.dout_wr_en !== 1'b1) bad_hold++;
            if (bus.s0_rd_en !== 1'b0 || bus.s1_rd_en !== 1'b0) bad_rd++;
        end
        checks++; if (held !== 256'h301) $display("FAIL bp_held: got %0h expected 301", held); else passes++;
        checks++; if (bad_hold != 0) $display("FAIL bp_hold: got %0d changed cycles expected 0", bad_hold); else passes++;
        checks++; if (bad_rd != 0) $display("FAIL bp_rd_en: got %0d accept cycles expected 0", bad_rd); else passes++;
        checks++; if (errs != errs0) $display("FAIL bp_err: got %0d pulses expected 0", errs - errs0); else passes++;
        @(posedge clk);
        #2;
        bus.dout_ready = 1'b1;
        wait_drain(50, ok);
        checks++; if (!ok) $display("FAIL bp_drain: got timeout expected drain"); else passes++;
        checks++; if (oq.size() != 4) $display("FAIL bp_nbeats: got %0d expected 4", oq.size()); else passes++;
        if (oq.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (oq[k].data !== 256'(32'h300 + 32'(k)) || oq[k].last !== (k == 3))
                    $display("FAIL bp_beat%0d: got %0h/%b expected %0h/%b", k, oq[k].data, oq[k].last, 32'h300 + k, (k == 3));
                else passes++;
            end
        end
        e0 += 1;
        checks++; if (bus.cnt_frm0 !== CW'(e0)) $display("FAIL bp_cnt0: got %0d expected %0d", bus.cnt_frm0, e0 % 16); else passes++;
    endtask

    task automatic test_timeout();
        bit ok;
        int errs0;
        oq.delete();
        errs0 = errs;
        q1.push_back({1'b0, 256'h400});
        q0.push_back({1'b1, 256'h500});
        wait_drain(100, ok);
        checks++; if (!ok) $display("FAIL to_drain: got timeout expected drain"); else passes++;
        checks++; if (errs - errs0 != 1) $display("FAIL to_pulses: got %0d expected 1", errs - errs0); else passes++;
        checks++; if (oq.size() != 2) $display("FAIL to_nbeats: got %0d expected 2", oq.size()); else passes++;
        if (oq.size() == 2) begin
            checks++; if (oq[0].data !== 256'h400 || oq[0].last !== 1'b0) $display("FAIL to_trunc: got %0h/%b expected 400/0", oq[0].data, oq[0].last); else passes++;
            checks++; if (oq[1].data !== 256'h500 || oq[1].last !== 1'b1) $display("FAIL to_next: got %0h/%b expected 500/1", oq[1].data, oq[1].last); else passes++;
            checks++; if (err_cyc - int'(oq[0].cyc) != 16) $display("FAIL to_delay: got %0d expected 16", err_cyc - int'(oq[0].cyc)); else passes++;
            checks++; if (int'(oq[1].cyc) <= err_cyc) $display("FAIL to_order: got %0d expected > %0d", oq[1].cyc, err_cyc); else passes++;
        end
        e0 += 1;
        checks++; if (bus.cnt_frm1 !== CW'(e1)) $display("FAIL to_cnt1: got %0d expected %0d", bus.cnt_frm1, e1 % 16); else passes++;
        checks++; if (bus.cnt_frm0 !== CW'(e0)) $display("FAIL to_cnt0: got %0d expected %0d", bus.cnt_frm0, e0 % 16); else passes++;
    endtask

    task automatic test_counter_wrap();
        bit ok;
        oq.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        tick(2);
        checks++; if (bus.cnt_frm0 !== CW'(0)) $display("FAIL wrap_rst: got %0d expected 0", bus.cnt_frm0); else passes++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) q0.push_back({1'b1, 256'(32'h600 + 32'(i))});
        wait_drain(200, ok);
        checks++; if (!ok) $display("FAIL wrap_drain16: got timeout expected drain"); else passes++;
        checks++; if (bus.cnt_frm0 !== CW'(0)) $display("FAIL wrap_cnt16: got %0d expected 0", bus.cnt_frm0); else passes++;
        q0.push_back({1'b1, 256'h610});
        wait_drain(50, ok);
        checks++; if (!ok) $display("FAIL wrap_drain17: got timeout expected drain"); else passes++;
        checks++; if (oq.size() != 17) $display("FAIL wrap_nbeats: got %0d expected 17", oq.size()); else passes++;
        checks++; if (bus.cnt_frm0 !== CW'(1)) $display("FAIL wrap_cnt17: got %0d expected 1", bus.cnt_frm0); else passes++;
        checks++; if (bus.cnt_frm1 !== CW'(0)) $display("FAIL wrap_cnt1: got %0d expected 0", bus.cnt_frm1); else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_contention();
        test_single_frame();
        test_back_pressure();
        test_timeout();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
